// File: rtl/plane_renderer.sv
// plane_renderer: pixel writer fed by the plane control block.
// Turns ten latched plane positions plus a visibility mask into one-pixel-per-cycle
// writes for a 160x120 VGA adapter: sprite draw, sprite erase or full-screen clear.
// Optional build macro RENDER_CLIP_EN suppresses writes for sprite pixels that land
// outside the screen; cycle timing is identical with or without it.
module plane_renderer #(
  parameter int unsigned SPRITE_W    = 4,
  parameter int unsigned SPRITE_H    = 4,
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120,
  parameter logic [2:0]  DRAW_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [79:0] x_bus,
  input  logic [79:0] y_bus,
  input  logic [9:0]  vis,
  input  logic [1:0]  op,
  input  logic        load_coord,
  input  logic        enable_datapath,
  input  logic        plot,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  colour,
  output logic        writeEn,
  output logic        busy,
  output logic        done
);

  localparam int unsigned NumPlanes = 10;
  localparam int unsigned ColW      = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int unsigned RowW      = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  localparam logic [ColW-1:0] ColLast = ColW'(SPRITE_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(SPRITE_H - 1);
  localparam logic [7:0]      CxLast  = 8'(SCREEN_W - 1);
  localparam logic [6:0]      CyLast  = 7'(SCREEN_H - 1);
  localparam logic [3:0]      IdxLast = 4'(NumPlanes - 1);

  localparam logic [1:0] OpErase = 2'b00;
  localparam logic [1:0] OpDraw  = 2'b01;
  localparam logic [1:0] OpClear = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StSel,
    StDraw,
    StClear,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [3:0]      idx_q, idx_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic [7:0]      cx_q, cx_d;
  logic [6:0]      cy_q, cy_d;

  // Shadow copies of the plane positions, frozen for the duration of a pass
  logic [7:0]      x_sh_q [NumPlanes];
  logic [7:0]      x_sh_d [NumPlanes];
  logic [7:0]      y_sh_q [NumPlanes];
  logic [7:0]      y_sh_d [NumPlanes];
  logic [9:0]      vis_q, vis_d;

  logic [7:0]      vga_x_q, vga_x_d;
  logic [6:0]      vga_y_q, vga_y_d;
  logic [2:0]      colour_q, colour_d;
  logic            write_en_q, write_en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [8:0]      x_sum, y_sum;

  // Next-state logic: pass sequencing, counters and shadow capture
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    col_d   = col_q;
    row_d   = row_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    x_sh_d  = x_sh_q;
    y_sh_d  = y_sh_q;
    vis_d   = vis_q;

    unique case (state_q)
      StIdle: begin
        if (load_coord) begin
          for (int i = 0; i < NumPlanes; i++) begin
            x_sh_d[i] = x_bus[8*i +: 8];
            y_sh_d[i] = y_bus[8*i +: 8];
          end
          vis_d = vis;
        end
        if (plot && enable_datapath) begin
          op_d = op;
          unique case (op)
            OpErase, OpDraw: begin
              state_d = StSel;
              idx_d   = '0;
            end
            OpClear: begin
              state_d = StClear;
              cx_d    = '0;
              cy_d    = '0;
            end
            default: state_d = StDone;
          endcase
        end
      end

      StSel: begin
        if (vis_q[idx_q]) begin
          state_d = StDraw;
          col_d   = '0;
          row_d   = '0;
        end else if (idx_q == IdxLast) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end

      StDraw: begin
        if (col_q == ColLast) begin
          col_d = '0;
          if (row_q == RowLast) begin
            row_d = '0;
            if (idx_q == IdxLast) begin
              state_d = StDone;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = StSel;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end

      StClear: begin
        if (cx_q == CxLast) begin
          cx_d = '0;
          if (cy_q == CyLast) begin
            state_d = StDone;
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop
  always_comb begin
    vga_x_d    = '0;
    vga_y_d    = '0;
    colour_d   = '0;
    write_en_d = 1'b0;
    busy_d     = (state_d == StSel) || (state_d == StDraw) || (state_d == StClear);
    done_d     = (state_d == StDone);
    x_sum      = {1'b0, x_sh_q[idx_d]} + 9'(col_d);
    y_sum      = {1'b0, y_sh_q[idx_d]} + 9'(row_d);

    if (state_d == StDraw) begin
      write_en_d = 1'b1;
      vga_x_d    = x_sum[7:0];
      vga_y_d    = y_sum[6:0];
      colour_d   = (op_d == OpDraw) ? DRAW_COLOUR : BG_COLOUR;
`ifdef RENDER_CLIP_EN
      if ((x_sum >= 9'(SCREEN_W)) || (y_sum >= 9'(SCREEN_H))) begin
        write_en_d = 1'b0;
      end
`endif
    end else if (state_d == StClear) begin
      write_en_d = 1'b1;
      vga_x_d    = cx_d;
      vga_y_d    = cy_d;
      colour_d   = BG_COLOUR;
    end
  end

`ifndef RENDER_CLIP_EN
  // Upper sum bits only matter when clipping is built in
  logic unused_sum_msbs;
  assign unused_sum_msbs = ^{x_sum[8], y_sum[8:7]};
`endif

  // State, counter, shadow and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      op_q       <= '0;
      idx_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      x_sh_q     <= '{default: '0};
      y_sh_q     <= '{default: '0};
      vis_q      <= '0;
      vga_x_q    <= '0;
      vga_y_q    <= '0;
      colour_q   <= '0;
      write_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      x_sh_q     <= x_sh_d;
      y_sh_q     <= y_sh_d;
      vis_q      <= vis_d;
      vga_x_q    <= vga_x_d;
      vga_y_q    <= vga_y_d;
      colour_q   <= colour_d;
      write_en_q <= write_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign vga_x   = vga_x_q;
  assign vga_y   = vga_y_q;
  assign colour  = colour_q;
  assign writeEn = write_en_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_plane_renderer.sv
// Directed bench for plane_renderer: expected pixels are queued as each pass is
// started and popped as the DUT strobes writeEn; pass length and done are checked too.
module tb_plane_renderer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [79:0] x_bus;
  logic [79:0] y_bus;
  logic [9:0]  vis;
  logic [1:0]  op;
  logic        load_coord;
  logic        enable_datapath;
  logic        plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  colour;
  logic        writeEn;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  plane_renderer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .x_bus           (x_bus),
    .y_bus           (y_bus),
    .vis             (vis),
    .op              (op),
    .load_coord      (load_coord),
    .enable_datapath (enable_datapath),
    .plot            (plot),
    .vga_x           (vga_x),
    .vga_y           (vga_y),
    .colour          (colour),
    .writeEn         (writeEn),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_plane(input int i, input int x, input int y);
    x_bus[8*i +: 8] = 8'(x);
    y_bus[8*i +: 8] = 8'(y);
  endtask

  // Reference sprite: col fastest, x wraps mod 256, y keeps 7 bits
  task automatic push_plane(input int xi, input int yi, input logic [2:0] c);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        int   xs;
        int   ys;
        bit   keep;
        pix_t p;
        xs   = xi + k;
        ys   = yi + r;
        keep = 1'b1;
`ifdef RENDER_CLIP_EN
        if (xs >= 160 || ys >= 120) keep = 1'b0;
`endif
        p.x = 8'(xs);
        p.y = 7'(ys);
        p.c = c;
        if (keep) exp_q.push_back(p);
      end
    end
  endtask

  task automatic start(input logic [1:0] o, input logic ld);
    op              = o;
    load_coord      = ld;
    plot            = 1'b1;
    enable_datapath = 1'b1;
  endtask

  // Clocks the start edge, then follows the pass to its done pulse.
  // poke_cyc >= 0 reloads x0=99 and re-pulses plot at that cycle of the pass.
  task automatic run_pass(input int exp_busy, input int budget, input int poke_cyc,
                          input string tag);
    int   busy_cnt;
    int   done_cyc;
    pix_t obs;
    pix_t expv;
    busy_cnt = 0;
    done_cyc = -1;
    tick();
    plot       = 1'b0;
    load_coord = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (writeEn) begin
        obs = {vga_x, vga_y, colour};
        if (exp_q.size() == 0) begin
          check({tag, "_unexpected_write"}, 32'(writeEn), 32'd0);
        end else begin
          expv = exp_q.pop_front();
          check({tag, "_pixel"}, 32'(obs), 32'(expv));
        end
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = c;
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_wr_at_done"}, 32'(writeEn), 32'd0);
        break;
      end
      if (c == poke_cyc) begin
        x_bus[7:0]      = 8'd99;
        load_coord      = 1'b1;
        plot            = 1'b1;
        enable_datapath = 1'b1;
      end else if (c == poke_cyc + 1) begin
        load_coord = 1'b0;
        plot       = 1'b0;
      end
      tick();
    end
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_busy));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({tag, "_missing_writes"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
    check({tag, "_done_pulse_len"}, 32'(done), 32'd0);
  endtask

  initial begin
    int wr;
    reset_n         = 1'b0;
    x_bus           = '0;
    y_bus           = '0;
    vis             = '0;
    op              = 2'b11;
    load_coord      = 1'b0;
    enable_datapath = 1'b0;
    plot            = 1'b0;
    tick();
    tick();
    check("reset_outputs", {13'd0, vga_x, vga_y, colour, writeEn, busy, done}, 32'd0);
    reset_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Reset in the middle of a clear, then a NOP pass
    start(2'b10, 1'b0);
    tick();
    plot = 1'b0;
    wr   = 0;
    for (int c = 0; c < 600; c++) begin
      if (writeEn) wr++;
      if (wr == 500) break;
      tick();
    end
    check("clear_progress", 32'(wr), 32'd500);
    reset_n = 1'b0;
    #1;
    check("rst_mid_wr", 32'(writeEn), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    tick();
    check("rst_hold_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    tick();
    start(2'b11, 1'b0);
    run_pass(0, 5, -1, "nop");

    // Plot without enable_datapath must not start a pass
    op              = 2'b01;
    plot            = 1'b1;
    enable_datapath = 1'b0;
    tick();
    tick();
    check("noen_busy", 32'(busy), 32'd0);
    check("noen_done", 32'(done), 32'd0);
    plot = 1'b0;

    // Full-screen clear
    for (int cy = 0; cy < 120; cy++) begin
      for (int cx = 0; cx < 160; cx++) begin
        exp_q.push_back('{x: 8'(cx), y: 7'(cy), c: 3'b000});
      end
    end
    start(2'b10, 1'b0);
    run_pass(19200, 19300, -1, "clear");

    // Single plane draw, load and plot in the same cycle
    set_plane(0, 10, 20);
    vis = 10'b0000000001;
    push_plane(10, 20, 3'b111);
    start(2'b01, 1'b1);
    run_pass(26, 100, -1, "draw1");

    // Erase planes 0 and 9, loaded one cycle ahead of plot
    set_plane(9, 50, 60);
    vis        = 10'b1000000001;
    load_coord = 1'b1;
    tick();
    load_coord = 1'b0;
    push_plane(10, 20, 3'b000);
    push_plane(50, 60, 3'b000);
    start(2'b00, 1'b0);
    run_pass(42, 100, -1, "erase2");

    // Load and plot during a pass are ignored
    vis = 10'b0000000001;
    push_plane(10, 20, 3'b111);
    start(2'b01, 1'b1);
    run_pass(26, 100, 5, "frozen");
    for (int i = 0; i < 3; i++) begin
      check("no_requeue_busy", 32'(busy), 32'd0);
      tick();
    end
    push_plane(10, 20, 3'b111);
    start(2'b01, 1'b0);
    run_pass(26, 100, -1, "shadow_kept");

    // Bottom-right corner: clipped or wrapped depending on build
    set_plane(0, 158, 118);
    vis = 10'b0000000001;
    push_plane(158, 118, 3'b111);
    start(2'b01, 1'b1);
    run_pass(26, 100, -1, "corner");

    // Coordinates near 255/127 exercise modulo wrap
    set_plane(3, 254, 126);
    vis = 10'b0000001000;
    push_plane(254, 126, 3'b111);
    start(2'b01, 1'b1);
    run_pass(26, 100, -1, "wrap");

    // No visible planes: ten select cycles, no writes
    vis = '0;
    start(2'b01, 1'b1);
    run_pass(10, 50, -1, "novis");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
